io_port_unit: RTL

IO_PORT_UNIT -- requirements
Module: io_port_unit

---
 rtl/io_port_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/io_port_unit.sv
// Two independent CPU-facing port paths: a synchronized, change-flagged P1 input
// register and a FIFO-buffered P0 output that is paced by a small drain FSM.
module io_port_unit #(
  parameter int WIDTH       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] P1_data_in,
  input  logic             cpu_rd_p1,
  output logic [WIDTH-1:0] p1_rdata,
  output logic             p1_changed,
  input  logic             cpu_wr_p0,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             wr_ready,
  output logic             overflow,
  output logic [WIDTH-1:0] P0_data_out,
  output logic             P0_strobe,
  output logic             busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_e;

  // P1 input path
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] p1_last_q, p1_last_d;
  logic [WIDTH-1:0] p1_rdata_q, p1_rdata_d;
  logic             p1_changed_q, p1_changed_d;

  // P0 output path
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] p0_data_q, p0_data_d;
  logic             p0_strobe_q, p0_strobe_d;
  logic             overflow_q, overflow_d;
  state_e           state_q, state_d;

  logic full;
  logic push;
  logic pop;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    s1_d         = P1_data_in;
    s2_d         = s1_q;
    p1_last_d    = p1_last_q;
    p1_rdata_d   = p1_rdata_q;
    p1_changed_d = p1_changed_q;
    if (cpu_rd_p1) begin
      p1_rdata_d   = p1_last_q;
      p1_changed_d = 1'b0;
    end
    // A change landing on the read edge wins: the flag stays set for the next read.
    if (s2_q != p1_last_q) begin
      p1_last_d    = s2_q;
      p1_changed_d = 1'b1;
    end
  end

  // Fullness is judged from the registered count only, so a same-edge pop never frees a slot.
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign wr_ready = ~full;
  assign push     = cpu_wr_p0 & ~full;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    p0_data_d   = p0_data_q;
    p0_strobe_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          p0_data_d   = mem_q[rd_ptr_q];
          p0_strobe_d = 1'b1;
          hold_d      = HW'(HOLD_CYCLES);
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Leaving as the counter reaches zero gives one update per HOLD_CYCLES+1 cycles.
        hold_d = hold_q - HW'(1);
        if (hold_q == HW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (cpu_wr_p0 & full);
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      p1_last_q    <= '0;
      p1_rdata_q   <= '0;
      p1_changed_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= '0;
      p0_data_q    <= '0;
      p0_strobe_q  <= 1'b0;
      overflow_q   <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      p1_last_q    <= p1_last_d;
      p1_rdata_q   <= p1_rdata_d;
      p1_changed_q <= p1_changed_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      p0_data_q    <= p0_data_d;
      p0_strobe_q  <= p0_strobe_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after a push has written it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cpu_wdata;
    end
  end

  assign p1_rdata    = p1_rdata_q;
  assign p1_changed  = p1_changed_q;
  assign overflow    = overflow_q;
  assign P0_data_out = p0_data_q;
  assign P0_strobe   = p0_strobe_q;
  assign busy        = (count_q != '0) || (state_q != ST_IDLE);

endmodule
